// File: rtl/s_seq_pkg.sv
// Shared types for the RC4 key-search sequencer: state encoding, s_memory grant
// encoding and default widths.
package s_seq_pkg;

  localparam int KEY_W_DEF          = 24;
  localparam int ADDR_W_DEF         = 8;
  localparam int DATA_W_DEF         = 8;
  localparam int TIMEOUT_CYCLES_DEF = 4096;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_SHUFFLE,
    ST_PRGA,
    ST_NEXT_KEY,
    ST_FOUND,
    ST_EXHAUSTED,
    ST_TIMEOUT
  } seq_state_t;

  // Which requester owns s_memory; also meant for status/LED decoding.
  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_INIT,
    GRANT_SHUFFLE,
    GRANT_PRGA
  } grant_t;

  function automatic grant_t grant_of(input seq_state_t s);
    case (s)
      ST_INIT:    return GRANT_INIT;
      ST_SHUFFLE: return GRANT_SHUFFLE;
      ST_PRGA:    return GRANT_PRGA;
      default:    return GRANT_NONE;
    endcase
  endfunction

  function automatic logic is_phase(input seq_state_t s);
    return (s == ST_INIT) || (s == ST_SHUFFLE) || (s == ST_PRGA);
  endfunction

endpackage

// File: rtl/phase_watchdog.sv
// Per-phase cycle counter: cleared on phase entry, counts while enabled, and
// flags expiry on the last allowed cycle.
module phase_watchdog #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  // Independent of clear, so the sequencer's next-state logic has no loop.
  assign expire = enable && (count == LAST);

endmodule

// File: rtl/s_mem_sequencer.sv
// Top-level RC4 key-search scheduler: sequences init/shuffle/PRGA sub-FSMs,
// grants the single-port s_memory to the active phase and steps the key.
module s_mem_sequencer
  import s_seq_pkg::*;
#(
  parameter int KEY_W          = KEY_W_DEF,
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              start_init,
  output logic              start_shuffle,
  output logic              start_prga,
  input  logic              finish_init,
  input  logic              finish_shuffle,
  input  logic              finish_prga,
  input  logic              prga_valid,
  input  logic              wren_init,
  input  logic              wren_shuffle,
  input  logic              wren_prga,
  input  logic [ADDR_W-1:0] addr_init,
  input  logic [ADDR_W-1:0] addr_shuffle,
  input  logic [ADDR_W-1:0] addr_prga,
  input  logic [DATA_W-1:0] data_init,
  input  logic [DATA_W-1:0] data_shuffle,
  input  logic [DATA_W-1:0] data_prga,
  output logic              s_wren,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_data,
  output logic [KEY_W-1:0]  key,
  output logic              busy,
  output logic              done,
  output logic              found
);

  seq_state_t state, state_next;
  logic       launch;
  logic       phase_entry;
  logic       expire;
  logic       key_clr;
  logic       key_inc;
  grant_t     grant;

  assign phase_entry = is_phase(state_next) && (state_next != state);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      launch <= 1'b0;
      key    <= '0;
    end else begin
      state  <= state_next;
      launch <= phase_entry;
      if (key_clr) begin
        key <= '0;
      end else if (key_inc) begin
        key <= key + 1'b1;
      end
    end
  end

  phase_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk   (clk),
    .rst_n (reset),
    .clear (phase_entry),
    .enable(is_phase(state)),
    .expire(expire)
  );

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    key_clr    = 1'b0;
    key_inc    = 1'b0;
    case (state)
      ST_IDLE, ST_FOUND, ST_EXHAUSTED, ST_TIMEOUT: begin
        if (start) begin
          state_next = ST_INIT;
          key_clr    = 1'b1;
        end
      end
      // A finish on the launch cycle is a leftover and is ignored; a real
      // finish beats a watchdog expiry in the same cycle.
      ST_INIT: begin
        if (finish_init && !launch)  state_next = ST_SHUFFLE;
        else if (expire)             state_next = ST_TIMEOUT;
      end
      ST_SHUFFLE: begin
        if (finish_shuffle && !launch) state_next = ST_PRGA;
        else if (expire)               state_next = ST_TIMEOUT;
      end
      ST_PRGA: begin
        if (finish_prga && !launch) begin
          if (prga_valid)  state_next = ST_FOUND;
          else if (&key)   state_next = ST_EXHAUSTED;
          else             state_next = ST_NEXT_KEY;
        end else if (expire) begin
          state_next = ST_TIMEOUT;
        end
      end
      ST_NEXT_KEY: begin
        key_inc    = 1'b1;
        state_next = ST_INIT;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign start_init    = launch && (state == ST_INIT);
  assign start_shuffle = launch && (state == ST_SHUFFLE);
  assign start_prga    = launch && (state == ST_PRGA);

  assign busy  = is_phase(state) || (state == ST_NEXT_KEY);
  assign done  = (state == ST_FOUND) || (state == ST_EXHAUSTED) || (state == ST_TIMEOUT);
  assign found = (state == ST_FOUND);

  // Pure mux off the state register: zero-latency grant, idle drives zeros.
  assign grant = grant_of(state);

  always_comb begin
    s_wren = 1'b0;
    s_addr = '0;
    s_data = '0;
    case (grant)
      GRANT_INIT: begin
        s_wren = wren_init;
        s_addr = addr_init;
        s_data = data_init;
      end
      GRANT_SHUFFLE: begin
        s_wren = wren_shuffle;
        s_addr = addr_shuffle;
        s_data = data_shuffle;
      end
      GRANT_PRGA: begin
        s_wren = wren_prga;
        s_addr = addr_prga;
        s_data = data_prga;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_s_mem_sequencer.sv
// Self-checking bench for s_mem_sequencer: the bench plays the three sub-FSMs
// with random finish delays and predicts each search outcome from the rules.
module tb_s_mem_sequencer;

  localparam int KEY_W  = 2;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int TMO    = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              start_init, start_shuffle, start_prga;
  logic              finish_init, finish_shuffle, finish_prga;
  logic              prga_valid;
  logic              wren_init, wren_shuffle, wren_prga;
  logic [ADDR_W-1:0] addr_init, addr_shuffle, addr_prga;
  logic [DATA_W-1:0] data_init, data_shuffle, data_prga;
  logic              s_wren;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_data;
  logic [KEY_W-1:0]  key;
  logic              busy, done, found;

  int checks = 0;
  int errors = 0;
  int init_pulses = 0;

  s_mem_sequencer #(
    .KEY_W(KEY_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .start_init(start_init), .start_shuffle(start_shuffle), .start_prga(start_prga),
    .finish_init(finish_init), .finish_shuffle(finish_shuffle), .finish_prga(finish_prga),
    .prga_valid(prga_valid),
    .wren_init(wren_init), .wren_shuffle(wren_shuffle), .wren_prga(wren_prga),
    .addr_init(addr_init), .addr_shuffle(addr_shuffle), .addr_prga(addr_prga),
    .data_init(data_init), .data_shuffle(data_shuffle), .data_prga(data_prga),
    .s_wren(s_wren), .s_addr(s_addr), .s_data(s_data),
    .key(key), .busy(busy), .done(done), .found(found)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (start_init === 1'b1) init_pulses++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_reqs();
    wren_init    = 1'($urandom);
    wren_shuffle = 1'($urandom);
    wren_prga    = 1'($urandom);
    addr_init    = 8'($urandom);
    addr_shuffle = 8'($urandom);
    addr_prga    = 8'($urandom);
    data_init    = 8'($urandom);
    data_shuffle = 8'($urandom);
    data_prga    = 8'($urandom);
  endtask

  // Owner 0/1/2 = init/shuffle/prga; anything else expects an idle bus.
  task automatic check_grant(input int owner);
    logic [16:0] exp;
    #1;
    case (owner)
      0:       exp = {wren_init, addr_init, data_init};
      1:       exp = {wren_shuffle, addr_shuffle, data_shuffle};
      2:       exp = {wren_prga, addr_prga, data_prga};
      default: exp = '0;
    endcase
    check("grant", {15'd0, s_wren, s_addr, s_data}, {15'd0, exp});
  endtask

  task automatic set_finish(input int ph, input logic v);
    case (ph)
      0: finish_init    = v;
      1: finish_shuffle = v;
      2: finish_prga    = v;
      default: ;
    endcase
  endtask

  // Random finishes on the phases that are not currently active.
  task automatic set_strays(input int ph);
    finish_init    = (ph != 0) && ($urandom_range(0, 3) == 0);
    finish_shuffle = (ph != 1) && ($urandom_range(0, 3) == 0);
    finish_prga    = (ph != 2) && ($urandom_range(0, 3) == 0);
  endtask

  task automatic check_terminal(input string tag, input logic exp_found, input int exp_key);
    check({tag, "_done"},  done, 1);
    check({tag, "_found"}, found, exp_found);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_key"},   key, exp_key);
    check({tag, "_start"}, {start_init, start_shuffle, start_prga}, 0);
  endtask

  // One full search. valid_mask[k] says whether the PRGA pass for key k
  // reports a valid plaintext; shuf_d0 forces the key-0 shuffle finish delay.
  task automatic run_search(input logic [3:0] valid_mask, input int shuf_d0);
    int  d;
    int  k;
    int  base;
    bit  stop;
    logic exp_found;
    base = init_pulses;
    start = 1'b1;
    randomize_reqs();
    tick();
    start = 1'b0;
    k = 0;
    stop = 0;
    exp_found = 1'b0;
    while (!stop) begin
      for (int ph = 0; ph < 3 && !stop; ph++) begin
        check("launch", {start_init, start_shuffle, start_prga}, 3'b100 >> ph);
        check("busy_launch", busy, 1);
        check("key_phase", key, k);
        randomize_reqs();
        check_grant(ph);
        d = (ph == 1 && k == 0 && shuf_d0 != 0) ? shuf_d0 : $urandom_range(1, 5);
        set_strays(ph);
        set_finish(ph, 1'($urandom));
        prga_valid = 1'($urandom);
        for (int c = 2; c <= TMO && c <= d + 1; c++) begin
          tick();
          check("no_relaunch", {start_init, start_shuffle, start_prga}, 0);
          check("busy_phase", busy, 1);
          randomize_reqs();
          check_grant(ph);
          set_strays(ph);
          set_finish(ph, c == d + 1);
          prga_valid = (c == d + 1) ? valid_mask[k] : 1'($urandom);
        end
        tick();
        finish_init = 0; finish_shuffle = 0; finish_prga = 0;
        if (d >= TMO) begin
          check_terminal("timeout", 0, k);
          stop = 1;
        end else if (ph == 2) begin
          if (valid_mask[k]) begin
            check_terminal("found", 1, k);
            exp_found = 1'b1;
            stop = 1;
          end else if (k == 3) begin
            check_terminal("exhausted", 0, 3);
            stop = 1;
          end else begin
            check("nk_busy", busy, 1);
            check("nk_start", {start_init, start_shuffle, start_prga}, 0);
            check("nk_key", key, k);
            randomize_reqs();
            check_grant(3);
            set_strays(3);
            prga_valid = 1'($urandom);
            tick();
            finish_init = 0; finish_shuffle = 0; finish_prga = 0;
            k++;
          end
        end
      end
    end
    check("init_count", init_pulses - base, k + 1);
    // Terminal state holds through stray finishes while start stays low.
    for (int i = 0; i < 3; i++) begin
      randomize_reqs();
      check_grant(3);
      set_strays(3);
      tick();
      check("hold_done", done, 1);
      check("hold_found", found, exp_found);
      check("hold_busy", busy, 0);
    end
    finish_init = 0; finish_shuffle = 0; finish_prga = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    reset = 1'b0;
    start = 1'b0;
    finish_init = 0; finish_shuffle = 0; finish_prga = 0;
    prga_valid = 0;
    randomize_reqs();
    #3;
    check("rst_state", {busy, done, found}, 0);
    check("rst_key", key, 0);
    check("rst_start", {start_init, start_shuffle, start_prga}, 0);
    check("rst_bus", {s_wren, s_addr, s_data}, 0);
    #4 reset = 1'b1;

    // Stray finishes in IDLE must not move the FSM.
    finish_shuffle = 1'b1;
    finish_init    = 1'b1;
    tick();
    finish_shuffle = 1'b0;
    finish_init    = 1'b0;
    check("stray_idle", {busy, done, found}, 0);
    check("stray_idle_start", {start_init, start_shuffle, start_prga}, 0);
    tick();
    check("stray_idle2", {busy, done}, 0);

    run_search(4'b0001, 0);     // found at key 0
    run_search(4'b0100, 0);     // found at key 2
    run_search(4'b0000, 0);     // exhausted
    run_search(4'b0000, TMO);   // shuffle never finishes: timeout
    run_search(4'b1000, TMO-1); // finish on the last allowed cycle wins

    for (int r = 0; r < 25; r++) begin
      run_search(4'($urandom),
                 ($urandom_range(0, 4) == 0) ? int'($urandom_range(TMO - 2, TMO + 1)) : 0);
    end

    // Asynchronous reset in the middle of a PRGA phase.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    finish_init = 1'b1;
    tick();
    finish_init = 1'b0;
    tick();
    finish_shuffle = 1'b1;
    tick();
    finish_shuffle = 1'b0;
    check("mid_prga_launch", start_prga, 1);
    wren_prga = 1'b1;
    addr_prga = 8'h3C;
    #1;
    check("mid_prga_wren", s_wren, 1);
    reset = 1'b0;
    #1;
    check("rst_async_wren", s_wren, 0);
    check("rst_async_state", {busy, done, found}, 0);
    check("rst_async_key", key, 0);
    check("rst_async_start", {start_init, start_shuffle, start_prga}, 0);
    #2 reset = 1'b1;
    tick();
    check("post_rst_idle", {busy, done, found}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
